// File: rtl/histogram_pkg.sv
// histogram_pkg: shared types and helpers for the streaming histogram engine.
//   hist_state_e : controller states
//   sat_inc      : counter increment with saturate/wrap policy; returns {ovf, new}
package histogram_pkg;

  // Widest bin counter the shared increment helper supports.
  localparam int unsigned CNT_MAX_W = 64;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } hist_state_e;

  // Increment a cnt_w-bit counter held zero-extended in 'old'.
  // At all-ones the counter holds (sat_en=1) or wraps to zero, and ovf is raised.
  function automatic logic [CNT_MAX_W:0] sat_inc(input logic [CNT_MAX_W-1:0] old,
                                                  input int unsigned          cnt_w,
                                                  input logic                 sat_en);
    logic [CNT_MAX_W-1:0] max_val;
    logic [CNT_MAX_W:0]   res;
    if (cnt_w >= CNT_MAX_W) max_val = '1;
    else                    max_val = (CNT_MAX_W'(1) << cnt_w) - CNT_MAX_W'(1);
    if (old == max_val) begin
      res[CNT_MAX_W]     = 1'b1;
      res[CNT_MAX_W-1:0] = sat_en ? old : '0;
    end else begin
      res[CNT_MAX_W]     = 1'b0;
      res[CNT_MAX_W-1:0] = old + CNT_MAX_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/histogram_bin_ram.sv
// histogram_bin_ram: simple dual-port bin storage, 2^ADDR_W x DATA_W.
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr      read port, registered output rdata (read-first on address collision)
module histogram_bin_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/histogram_accum_core.sv
// histogram_accum_core: streaming histogram with pipelined read-modify-write bins.
//   ACLK/ARESETN      clock, synchronous active-low reset
//   s_pix_*           pixel stream (valid/ready/data/last)
//   cmd_clear         abort and zero all bins and counters (highest priority)
//   cmd_continue      leave DONE keeping bins, for multi-frame accumulation
//   cfg_sat_en        counter policy for the next frame: 1 saturate, 0 wrap
//   rd_en/rd_addr     bin readout request (IDLE/DONE only), answered next cycle
//   rd_valid/rd_data  readout response
//   busy/frame_done   status; ovf sticky bin overflow; pix_cnt accepted pixels
module histogram_accum_core
  import histogram_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BIN_ADDR_W = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  s_pix_valid,
  output logic                  s_pix_ready,
  input  logic [PIX_W-1:0]      s_pix_data,
  input  logic                  s_pix_last,
  input  logic                  cmd_clear,
  input  logic                  cmd_continue,
  input  logic                  cfg_sat_en,
  input  logic                  rd_en,
  input  logic [BIN_ADDR_W-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ovf,
  output logic [CNT_W-1:0]      pix_cnt
);

  if (BIN_ADDR_W > PIX_W) begin : g_bad_bin_w
    $error("histogram_accum_core: BIN_ADDR_W must be <= PIX_W");
  end
  if (CNT_W > CNT_MAX_W) begin : g_bad_cnt_w
    $error("histogram_accum_core: CNT_W exceeds sat_inc width");
  end

  hist_state_e state_q, state_d;

  logic [BIN_ADDR_W-1:0] pix_bin, clr_addr_q, s1_addr_q, ram_waddr, ram_raddr;
  logic                  accept, rd_service, ram_we, ram_re;
  logic                  s1_valid_q, fwd_valid_q, sat_q, ovf_q, rd_valid_q, s1_ovf;
  logic [CNT_W-1:0]      ram_rdata, ram_wdata, fwd_data_q, s1_old, s1_new, pix_cnt_q;
  logic [CNT_MAX_W:0]    inc_res;

  assign pix_bin = s_pix_data[PIX_W-1 -: BIN_ADDR_W];

  if (BIN_ADDR_W < PIX_W) begin : g_pix_lo
    logic unused_pix_lo;
    assign unused_pix_lo = ^s_pix_data[PIX_W-BIN_ADDR_W-1:0];
  end
  if (CNT_W < CNT_MAX_W) begin : g_inc_hi
    logic unused_inc_hi;
    assign unused_inc_hi = ^inc_res[CNT_MAX_W-1:CNT_W];
  end

  // Ready is withdrawn in the clear cycle so no pixel is accepted and then flushed.
  assign s_pix_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !cmd_clear;
  assign accept      = s_pix_valid && s_pix_ready;
  // Pixels own the RAM read port; readout only uses it when no pixel is taken.
  assign rd_service  = rd_en && !cmd_clear &&
                       ((state_q == DONE) || ((state_q == IDLE) && !accept));

  assign ram_re    = accept || rd_service;
  assign ram_raddr = rd_service ? rd_addr : pix_bin;

  // S1: the RAM is read-first, so a bin written by S1 while S0 reads it returns
  // stale data; the forwarded value replaces it one cycle later.
  always_comb begin
    s1_old  = fwd_valid_q ? fwd_data_q : ram_rdata;
    inc_res = sat_inc(CNT_MAX_W'(s1_old), CNT_W, sat_q);
    s1_new  = inc_res[CNT_W-1:0];
    s1_ovf  = inc_res[CNT_MAX_W];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr_q;
    ram_wdata = s1_new;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end else if (s1_valid_q) begin
      ram_we = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = CLEAR;
    end else begin
      unique case (state_q)
        CLEAR:   if (clr_addr_q == '1) state_d = IDLE;
        IDLE:    if (accept) state_d = s_pix_last ? DRAIN : ACCUM;
        ACCUM:   if (accept && s_pix_last) state_d = DRAIN;
        // S0 is empty here and S1 retires the last pixel in this cycle.
        DRAIN:   state_d = DONE;
        DONE:    if (cmd_continue) state_d = IDLE;
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      s1_valid_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      pix_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_service;
      if (cmd_clear) begin
        clr_addr_q  <= '0;
        s1_valid_q  <= 1'b0;
        fwd_valid_q <= 1'b0;
        ovf_q       <= 1'b0;
        pix_cnt_q   <= '0;
      end else begin
        if (state_q == CLEAR) clr_addr_q <= clr_addr_q + BIN_ADDR_W'(1);
        s1_valid_q  <= accept;
        fwd_valid_q <= accept && s1_valid_q && (s1_addr_q == pix_bin);
        if (s1_valid_q && s1_ovf) ovf_q <= 1'b1;
        if (accept && (pix_cnt_q != '1)) pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        if (accept && (state_q == IDLE)) sat_q <= cfg_sat_en;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    s1_addr_q  <= pix_bin;
    fwd_data_q <= s1_new;
  end

  histogram_bin_ram #(
    .ADDR_W (BIN_ADDR_W),
    .DATA_W (CNT_W)
  ) u_bin_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? ram_rdata : '0;
  assign busy       = (state_q == CLEAR) || (state_q == ACCUM) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
  assign ovf        = ovf_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_histogram_accum_core.sv
// Testbench for histogram_accum_core (PIX_W=8, BIN_ADDR_W=4, CNT_W=4).
// Reference model: per-bin counts in an array updated per accepted pixel.
module tb_histogram_accum_core;

  localparam int unsigned PW    = 8;
  localparam int unsigned BW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned NBINS = 16;
  localparam int unsigned CMAX  = 15;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          s_pix_valid, s_pix_ready, s_pix_last;
  logic [PW-1:0] s_pix_data;
  logic          cmd_clear, cmd_continue, cfg_sat_en;
  logic          rd_en, rd_valid;
  logic [BW-1:0] rd_addr;
  logic [CW-1:0] rd_data, pix_cnt;
  logic          busy, frame_done, ovf;

  histogram_accum_core #(
    .PIX_W      (PW),
    .BIN_ADDR_W (BW),
    .CNT_W      (CW)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .s_pix_valid  (s_pix_valid),
    .s_pix_ready  (s_pix_ready),
    .s_pix_data   (s_pix_data),
    .s_pix_last   (s_pix_last),
    .cmd_clear    (cmd_clear),
    .cmd_continue (cmd_continue),
    .cfg_sat_en   (cfg_sat_en),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .ovf          (ovf),
    .pix_cnt      (pix_cnt)
  );

  always #5 ACLK = ~ACLK;

  int          total = 0;
  int          bad   = 0;
  int unsigned m_bins [NBINS];
  int unsigned m_cnt;
  bit          m_ovf, m_sat, in_frame;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NBINS); i++) m_bins[i] = 0;
    m_cnt    = 0;
    m_ovf    = 1'b0;
    in_frame = 1'b0;
  endtask

  task automatic model_accept(input logic [PW-1:0] d);
    int b;
    b = int'(d) / (1 << (PW - BW));
    if (m_bins[b] == CMAX) begin
      m_ovf = 1'b1;
      if (!m_sat) m_bins[b] = 0;
    end else begin
      m_bins[b] = m_bins[b] + 1;
    end
    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
  endtask

  // Called one step after the edge that entered CLEAR: 16 sweep cycles follow.
  task automatic wait_clear_done();
    check_eq("clr_busy0", 64'(busy), 64'(1));
    check_eq("clr_ready0", 64'(s_pix_ready), 64'(0));
    repeat (15) tick();
    check_eq("clr_busy15", 64'(busy), 64'(1));
    tick();
    check_eq("clr_idle", 64'(busy), 64'(0));
    check_eq("clr_idle_ready", 64'(s_pix_ready), 64'(1));
  endtask

  task automatic do_clear();
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    model_clear();
    check_eq("clr_pixcnt", 64'(pix_cnt), 64'(0));
    check_eq("clr_ovf", 64'(ovf), 64'(0));
    wait_clear_done();
  endtask

  task automatic send_pixel(input logic [PW-1:0] d, input bit last);
    s_pix_valid = 1'b1;
    s_pix_data  = d;
    s_pix_last  = last;
    #1;
    check_eq("pix_ready", 64'(s_pix_ready), 64'(1));
    if (!in_frame) begin
      m_sat    = cfg_sat_en;
      in_frame = 1'b1;
    end
    model_accept(d);
    tick();
    s_pix_valid = 1'b0;
    s_pix_last  = 1'b0;
    if (last) in_frame = 1'b0;
  endtask

  // Called one step after the last-pixel accept edge.
  task automatic end_frame_check();
    check_eq("drain_fd", 64'(frame_done), 64'(0));
    check_eq("drain_busy", 64'(busy), 64'(1));
    tick();
    check_eq("done_fd", 64'(frame_done), 64'(1));
    check_eq("done_busy", 64'(busy), 64'(0));
    check_eq("done_ready", 64'(s_pix_ready), 64'(0));
  endtask

  task automatic read_bin(input int a);
    rd_en   = 1'b1;
    rd_addr = BW'(a);
    tick();
    rd_en = 1'b0;
    check_eq("rd_valid", 64'(rd_valid), 64'(1));
    check_eq($sformatf("rd_bin%0d", a), 64'(rd_data), 64'(m_bins[a]));
  endtask

  task automatic read_all();
    for (int i = 0; i < int'(NBINS); i++) read_bin(i);
    tick();
    check_eq("rd_drop", 64'(rd_valid), 64'(0));
    check_eq("pix_cnt", 64'(pix_cnt), 64'(m_cnt));
    check_eq("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic do_continue();
    cmd_continue = 1'b1;
    tick();
    cmd_continue = 1'b0;
    check_eq("cont_fd", 64'(frame_done), 64'(0));
    check_eq("cont_ready", 64'(s_pix_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] d;
    int            len;
    ARESETN = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0; s_pix_last = 1'b0;
    cmd_clear = 1'b0; cmd_continue = 1'b0; cfg_sat_en = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    model_clear();
    m_sat = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'(1));
    check_eq("rst_ready", 64'(s_pix_ready), 64'(0));
    check_eq("rst_rd_valid", 64'(rd_valid), 64'(0));
    check_eq("rst_rd_data", 64'(rd_data), 64'(0));
    check_eq("rst_fd", 64'(frame_done), 64'(0));
    check_eq("rst_ovf", 64'(ovf), 64'(0));
    check_eq("rst_pixcnt", 64'(pix_cnt), 64'(0));
    ARESETN = 1'b1;
    wait_clear_done();
    read_all();

    // Mixed bins with back-to-back repeats
    send_pixel(8'h05, 1'b0);
    send_pixel(8'h15, 1'b0);
    send_pixel(8'h15, 1'b0);
    send_pixel(8'h15, 1'b0);
    send_pixel(8'hF0, 1'b1);
    end_frame_check();
    read_all();
    check_eq("t2_bin1", 64'(m_bins[1]), 64'(3));
    do_clear();

    // Saturation then wrap on a single bin
    for (int pass = 0; pass < 2; pass++) begin
      cfg_sat_en = (pass == 0);
      for (int k = 0; k < 20; k++) send_pixel(8'h30, k == 19);
      end_frame_check();
      read_all();
      check_eq("t3_ovf", 64'(ovf), 64'(1));
      do_clear();
    end

    // Two frames accumulate across cmd_continue; readout ignored in ACCUM
    cfg_sat_en = 1'b1;
    send_pixel(8'h20, 1'b0);
    rd_en   = 1'b1;
    rd_addr = 4'h2;
    tick();
    rd_en = 1'b0;
    check_eq("rd_in_accum", 64'(rd_valid), 64'(0));
    send_pixel(8'h20, 1'b0);
    send_pixel(8'h20, 1'b1);
    end_frame_check();
    s_pix_valid = 1'b1;
    s_pix_data  = 8'h20;
    #1;
    check_eq("bp_done", 64'(s_pix_ready), 64'(0));
    s_pix_valid = 1'b0;
    do_continue();
    send_pixel(8'h20, 1'b0);
    send_pixel(8'h20, 1'b1);
    end_frame_check();
    read_all();
    check_eq("t4_pixcnt", 64'(pix_cnt), 64'(5));
    do_clear();

    // Clear in the middle of a frame
    for (int k = 0; k < 7; k++) send_pixel(8'($urandom), 1'b0);
    s_pix_valid = 1'b1;
    cmd_clear   = 1'b1;
    #1;
    check_eq("clr_mid_ready", 64'(s_pix_ready), 64'(0));
    tick();
    cmd_clear   = 1'b0;
    s_pix_valid = 1'b0;
    model_clear();
    check_eq("clr_mid_pixcnt", 64'(pix_cnt), 64'(0));
    wait_clear_done();
    read_all();

    // Randomized frames: few bins for dense hazards, gaps, policy toggles mid-frame
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 5) == 0) do_clear();
      cfg_sat_en = 1'($urandom);
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) begin
          rd_en   = 1'($urandom);
          rd_addr = BW'($urandom);
          cfg_sat_en = 1'($urandom);
          tick();
          rd_en = 1'b0;
          check_eq("rd_gap", 64'(rd_valid), 64'(0));
        end
        d[PW-1:PW-BW] = BW'($urandom_range(0, 3));
        d[PW-BW-1:0]  = (PW-BW)'($urandom);
        send_pixel(d, k == len - 1);
      end
      end_frame_check();
      read_all();
      do_continue();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
